// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the uart_tx_arbiter slice: FSM state encoding,
// requester limit and index-width helper.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE
    } arb_state_e;

    localparam int unsigned ARB_MAX_REQ = 4;

    // Width of a requester index; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the uart transmit handshake and arbiter status.
// slave = arbiter side, master = requesters/uart/observer side.
interface uart_tx_arbiter_if #(
    parameter int unsigned NREQ = 2
);
    import uart_arb_pkg::*;

    localparam int unsigned IW = idx_w(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              uart_transmit;
    logic [7:0]        uart_tx_byte;
    logic              uart_is_transmitting;
    logic [IW-1:0]     grant_id;
    logic              locked;
    logic              busy;

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        input  uart_is_transmitting,
        output req_ready,
        output uart_transmit,
        output uart_tx_byte,
        output grant_id,
        output locked,
        output busy
    );

    modport master (
        output req_valid,
        output req_data,
        output req_last,
        output uart_is_transmitting,
        input  req_ready,
        input  uart_transmit,
        input  uart_tx_byte,
        input  grant_id,
        input  locked,
        input  busy
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping, returned as one-hot grant plus binary index.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!any && req[(32'(ptr) + k) % NREQ]) begin
                any = 1'b1;
                idx = IW'((32'(ptr) + k) % NREQ);
                gnt[(32'(ptr) + k) % NREQ] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart transmitter between NREQ byte streams,
// with frame locking. Optional lock timeout: define UART_ARB_LOCK_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NREQ         = 2,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);

    localparam int unsigned IW = idx_w(NREQ);

    if (NREQ < 2 || NREQ > ARB_MAX_REQ || LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 65535) begin : g_bad_cfg
        $error("uart_tx_arbiter: parameter out of range");
    end

    arb_state_e    state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] lock_id_q, lock_id_d;
    logic [IW-1:0] grant_id_q, grant_id_d;
    logic          locked_q, locked_d;
    logic [7:0]    tx_byte_q, tx_byte_d;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            accept;
    logic            transmit;
    logic            to_expire;

    // While locked only the lock owner may compete; the picker stays lock-agnostic.
    always_comb begin
        eligible = bus.req_valid;
        if (locked_q) begin
            eligible            = '0;
            eligible[lock_id_q] = bus.req_valid[lock_id_q];
        end
    end

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req (eligible),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        accept   = (state_q == IDLE) && pick_any && !rst;
        transmit = (state_q == ISSUE) && !bus.uart_is_transmitting && !rst;
    end

`ifdef UART_ARB_LOCK_TIMEOUT_EN
    logic [15:0] to_cnt_q, to_cnt_d;

    // Counts consecutive stalled IDLE cycles; expiry drops the lock on the next edge.
    always_comb begin
        to_cnt_d  = '0;
        to_expire = 1'b0;
        if (state_q == IDLE && locked_q && !bus.req_valid[lock_id_q]) begin
            if (32'(to_cnt_q) + 32'd1 >= LOCK_TIMEOUT) begin
                to_expire = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    always_comb begin
        to_expire = 1'b0;
    end
`endif

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_id_d  = lock_id_q;
        grant_id_d = grant_id_q;
        locked_d   = locked_q;
        tx_byte_d  = tx_byte_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = ISSUE;
                    tx_byte_d  = bus.req_data[8*pick_idx +: 8];
                    grant_id_d = pick_idx;
                    rr_ptr_d   = pick_idx;
                    if (bus.req_last[pick_idx]) begin
                        locked_d = 1'b0;
                    end else begin
                        locked_d  = 1'b1;
                        lock_id_d = pick_idx;
                    end
                end else if (to_expire) begin
                    locked_d = 1'b0;
                end
            end
            ISSUE: begin
                if (transmit) begin
                    state_d = WAIT_START;
                end
            end
            WAIT_START: begin
                if (bus.uart_is_transmitting) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!bus.uart_is_transmitting) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= IW'(NREQ - 1);
            lock_id_q  <= '0;
            grant_id_q <= '0;
            locked_q   <= 1'b0;
            tx_byte_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_id_q  <= lock_id_d;
            grant_id_q <= grant_id_d;
            locked_q   <= locked_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    always_comb begin
        bus.req_ready     = accept ? pick_gnt : '0;
        bus.uart_transmit = transmit;
        bus.uart_tx_byte  = tx_byte_q;
        bus.grant_id      = grant_id_q;
        bus.locked        = locked_q;
        bus.busy          = (state_q != IDLE);
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random
// frame traffic checked against a frame-level round-robin reference.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int unsigned NREQ         = 3;
    localparam int unsigned LOCK_TIMEOUT = 1024;
    localparam int unsigned DEPTH        = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(NREQ)) ifc();

    uart_tx_arbiter #(
        .NREQ         (NREQ),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Per-requester byte queues as {last, data}
    logic [8:0]      mem [NREQ][DEPTH];
    int unsigned     head [NREQ];
    int unsigned     tail [NREQ];
    logic [NREQ-1:0] en;
    logic [NREQ-1:0] pend;

    // Behavioural uart and observation log
    int unsigned u_cnt;
    bit          u_start;
    bit          ext_busy;
    logic [7:0]  sent_b [$];
    int unsigned sent_r [$];
    logic [7:0]  exp_b [$];
    int unsigned exp_r [$];
    int unsigned acc_cyc [$];
    int unsigned acc_total, tx_pulses, cyc;
    bit          chk_lock_pending;
    bit          exp_locked;
    int unsigned exp_gid;
    logic [7:0]  last_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int unsigned r, input bit last, input logic [7:0] data);
        mem[r][tail[r]] = {last, data};
        tail[r]++;
    endtask

    function automatic bit all_empty();
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (head[i] < tail[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One clock: update drives on negedge, sample 1 time unit before posedge.
    task automatic cycle();
        logic [NREQ-1:0] acc;
        @(negedge clk);
        cyc++;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pend[i]) head[i]++;
        end
        pend = '0;
        if (u_start) begin
            u_cnt   = $urandom_range(2, 5);
            u_start = 1'b0;
        end else if (u_cnt > 0) begin
            u_cnt--;
        end
        ifc.uart_is_transmitting = (u_cnt > 0) || ext_busy;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (en[i] && head[i] < tail[i]) begin
                ifc.req_valid[i]      = 1'b1;
                ifc.req_data[8*i +: 8] = mem[i][head[i]][7:0];
                ifc.req_last[i]       = mem[i][head[i]][8];
            end else begin
                ifc.req_valid[i]      = 1'b0;
                ifc.req_data[8*i +: 8] = 8'h00;
                ifc.req_last[i]       = 1'b0;
            end
        end
        #4;
        if (chk_lock_pending) begin
            chk("grant_id_after_accept", 32'(ifc.grant_id), exp_gid);
            chk("locked_after_accept", 32'(ifc.locked), 32'(exp_locked));
            chk_lock_pending = 1'b0;
        end
        acc = ifc.req_ready & ifc.req_valid;
        if (ifc.req_ready != '0) begin
            chk("ready_onehot", $countones(ifc.req_ready), 1);
            chk("ready_only_when_valid", 32'(acc), 32'(ifc.req_ready));
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    pend[i]          = 1'b1;
                    exp_gid          = i;
                    exp_locked       = !mem[i][head[i]][8];
                    last_data        = mem[i][head[i]][7:0];
                    chk_lock_pending = 1'b1;
                    acc_total++;
                    acc_cyc.push_back(cyc);
                end
            end
        end
        if (ifc.uart_transmit) begin
            chk("tx_byte_at_pulse", 32'(ifc.uart_tx_byte), 32'(last_data));
            chk("busy_at_pulse", 32'(ifc.busy), 1);
            sent_b.push_back(ifc.uart_tx_byte);
            sent_r.push_back(exp_gid);
            tx_pulses++;
            u_start = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = '0;
        pend = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        u_cnt = 0;
        u_start = 1'b0;
        ext_busy = 1'b0;
        chk_lock_pending = 1'b0;
        sent_b.delete();
        sent_r.delete();
        acc_cyc.delete();
        acc_total = 0;
        tx_pulses = 0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic chk_reset_values(input string pfx);
        chk({pfx, "_req_ready"}, 32'(ifc.req_ready), 0);
        chk({pfx, "_uart_transmit"}, 32'(ifc.uart_transmit), 0);
        chk({pfx, "_uart_tx_byte"}, 32'(ifc.uart_tx_byte), 0);
        chk({pfx, "_grant_id"}, 32'(ifc.grant_id), 0);
        chk({pfx, "_locked"}, 32'(ifc.locked), 0);
        chk({pfx, "_busy"}, 32'(ifc.busy), 0);
    endtask

    task automatic drain(input int unsigned budget, input string tag);
        int unsigned n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            cycle();
            n++;
            done = all_empty() && (pend == '0) && !ifc.busy && (u_cnt == 0) && !u_start;
        end
        chk(tag, 32'(done), 1);
    endtask

    // Frame-level reference: whole frames in round-robin order from index 0.
    function automatic void model_order();
        int unsigned h [NREQ];
        int unsigned ptr, j;
        bit more, fin;
        exp_b.delete();
        exp_r.delete();
        for (int unsigned i = 0; i < NREQ; i++) h[i] = head[i];
        ptr = NREQ - 1;
        more = 1'b1;
        while (more) begin
            more = 1'b0;
            for (int unsigned k = 1; k <= NREQ; k++) begin
                j = (ptr + k) % NREQ;
                if (!more && h[j] < tail[j]) begin
                    fin = 1'b0;
                    while (!fin && h[j] < tail[j]) begin
                        exp_b.push_back(mem[j][h[j]][7:0]);
                        exp_r.push_back(j);
                        fin = mem[j][h[j]][8];
                        h[j]++;
                    end
                    ptr = j;
                    more = 1'b1;
                end
            end
        end
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned n, nf, len, delta;
        ifc.req_valid = '0;
        ifc.req_data  = '0;
        ifc.req_last  = '0;
        ifc.uart_is_transmitting = 1'b0;
        en = '0;
        cyc = 0;
        last_data = 8'h00;
        exp_gid = 0;
        exp_locked = 1'b0;

        do_reset();
        chk_reset_values("por");

        // Single byte from requester 0
        push(0, 1'b1, 8'h55);
        en = '1;
        cycle();
        chk("single_ready0", 32'(ifc.req_ready), 1);
        cycle();
        chk("single_pulse", 32'(ifc.uart_transmit), 1);
        chk("single_byte", 32'(ifc.uart_tx_byte), 32'h55);
        chk("single_ready_low", 32'(ifc.req_ready), 0);
        n = 0;
        do begin
            cycle();
            n++;
        end while (ifc.busy && n < 50);
        chk("single_busy_fall", 32'(ifc.busy), 0);
        chk("single_uart_idle_at_fall", 32'(ifc.uart_is_transmitting), 0);
        chk("single_accepts", acc_total, 1);
        chk("single_pulses", tx_pulses, 1);

        // Fairness between requesters 0 and 1
        do_reset();
        for (int unsigned k = 0; k < 8; k++) begin
            push(0, 1'b1, 8'(32'hA0 + k));
            push(1, 1'b1, 8'(32'hB0 + k));
        end
        en = '1;
        drain(600, "fair_drain");
        chk("fair_count", sent_b.size(), 16);
        for (int unsigned k = 0; k < 8 && 2*k+1 < sent_b.size(); k++) begin
            chk("fair_a", 32'(sent_b[2*k]), 32'hA0 + k);
            chk("fair_b", 32'(sent_b[2*k+1]), 32'hB0 + k);
        end
        chk("fair_pulses_eq_accepts", tx_pulses, acc_total);

        // Frame lock: requester 1 frame must not be interleaved by requester 0
        do_reset();
        push(0, 1'b1, 8'h01);
        push(0, 1'b1, 8'h77);
        push(1, 1'b0, 8'h10);
        push(1, 1'b0, 8'h11);
        push(1, 1'b1, 8'h12);
        en = '1;
        drain(300, "lock_drain");
        chk("lock_count", sent_b.size(), 5);
        if (sent_b.size() == 5) begin
            chk("lock_b0", 32'(sent_b[0]), 32'h01);
            chk("lock_b1", 32'(sent_b[1]), 32'h10);
            chk("lock_b2", 32'(sent_b[2]), 32'h11);
            chk("lock_b3", 32'(sent_b[3]), 32'h12);
            chk("lock_b4", 32'(sent_b[4]), 32'h77);
        end
        chk("lock_released", 32'(ifc.locked), 0);

        // Stall: lock owner drops valid while requester 1 waits
        do_reset();
        push(0, 1'b0, 8'h33);
        push(1, 1'b1, 8'h44);
        en = '1;
        repeat (2000) cycle();
`ifdef UART_ARB_LOCK_TIMEOUT_EN
        chk("stall_to_count", sent_b.size(), 2);
        if (sent_b.size() == 2 && acc_cyc.size() == 2) begin
            chk("stall_to_first", 32'(sent_b[0]), 32'h33);
            chk("stall_to_second", 32'(sent_b[1]), 32'h44);
            delta = acc_cyc[1] - acc_cyc[0];
            chk("stall_to_window", 32'(delta >= LOCK_TIMEOUT + 1 && delta <= LOCK_TIMEOUT + 36), 1);
        end
`else
        chk("stall_count", sent_b.size(), 1);
        if (sent_b.size() >= 1) chk("stall_first", 32'(sent_b[0]), 32'h33);
        chk("stall_locked", 32'(ifc.locked), 1);
        chk("stall_ready_low", 32'(ifc.req_ready), 0);
        chk("stall_idle", 32'(ifc.busy), 0);
`endif

        // Reset mid-frame while locked on requester 1
        do_reset();
        push(1, 1'b0, 8'h21);
        push(1, 1'b0, 8'h22);
        push(1, 1'b1, 8'h23);
        en = '1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(ifc.locked && ifc.busy && ifc.uart_is_transmitting) && n < 100);
        cycle();
        chk("rmid_found", 32'(n < 100), 1);
        chk("rmid_locked_before", 32'(ifc.locked), 1);
        chk("rmid_gid_before", 32'(ifc.grant_id), 1);
        do_reset();
        chk_reset_values("rmid");
        push(0, 1'b1, 8'h31);
        push(1, 1'b1, 8'h32);
        en = '1;
        drain(200, "rmid_drain");
        chk("rmid_count", sent_b.size(), 2);
        if (sent_b.size() == 2) begin
            chk("rmid_first_byte", 32'(sent_b[0]), 32'h31);
            chk("rmid_first_req", sent_r[0], 0);
            chk("rmid_second_byte", 32'(sent_b[1]), 32'h32);
        end

        // Busy uart held externally during ISSUE
        do_reset();
        push(0, 1'b1, 8'h5A);
        en = '1;
        cycle();
        chk("busyu_ready", 32'(ifc.req_ready), 1);
        ext_busy = 1'b1;
        ifc.uart_is_transmitting = 1'b1;
        repeat (50) cycle();
        chk("busyu_no_pulse", tx_pulses, 0);
        chk("busyu_held", 32'(ifc.busy), 1);
        ext_busy = 1'b0;
        drain(100, "busyu_drain");
        chk("busyu_one_pulse", tx_pulses, 1);
        if (sent_b.size() >= 1) chk("busyu_byte", 32'(sent_b[0]), 32'h5A);

        // Random frames on all requesters against the frame-level reference
        for (int unsigned round = 0; round < 4; round++) begin
            do_reset();
            for (int unsigned r = 0; r < NREQ; r++) begin
                nf = $urandom_range(1, 4);
                for (int unsigned f = 0; f < nf; f++) begin
                    len = $urandom_range(1, 3);
                    for (int unsigned b = 0; b < len; b++) begin
                        push(r, b == len - 1, 8'($urandom_range(0, 255)));
                    end
                end
            end
            model_order();
            en = '1;
            drain(3000, "rand_drain");
            chk("rand_count", sent_b.size(), exp_b.size());
            for (int unsigned k = 0; k < exp_b.size() && k < sent_b.size(); k++) begin
                chk("rand_byte", 32'(sent_b[k]), 32'(exp_b[k]));
                chk("rand_req", sent_r[k], exp_r[k]);
            end
            chk("rand_pulses_eq_accepts", tx_pulses, acc_total);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single `uart` transmitter between `NREQ` byte-stream requesters, such as the CPU console port and the debug monitor. It picks requesters round-robin and holds the grant across a multi-byte frame until the requester marks its last byte. It drives the `transmit`/`tx_byte` inputs of `uart` and watches its `is_transmitting` output. It sits between the requesters and the `uart` instance, so that instance no longer needs direct write access from the CPU.

## Interface
- `NREQ`, default 2: number of requesters, legal range 2..4.
- `LOCK_TIMEOUT`, default 1024: idle cycles before a frame lock is dropped. Used only when `UART_ARB_LOCK_TIMEOUT_EN` is defined; legal range 1..65535.
- `clk`  in  1  single clock; everything is on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  requester i has a byte on `req_data[8i+7:8i]`.
- `req_data`  in  8*NREQ  packed bytes, requester i at bits 8i+7:8i.
- `req_last`  in  NREQ  byte i is the final byte of its frame.
- `req_ready`  out  NREQ  one-hot or zero; the byte is accepted when valid&ready.
- `uart_transmit`  out  1  connects to `uart.transmit`.
- `uart_tx_byte`  out  8  connects to `uart.tx_byte`.
- `uart_is_transmitting`  in  1  from `uart.is_transmitting`.
- `grant_id`  out  $clog2(NREQ)  requester that owns the current or most recent byte.
- `locked`  out  1  a frame lock is held.
- `busy`  out  1  state != IDLE.

## Operation
- States and transitions:
  - IDLE: selects a requester. On acceptance, go to ISSUE.
  - ISSUE: `uart_transmit` = !`uart_is_transmitting`. When the pulse is emitted, go to WAIT_START.
  - WAIT_START: wait for `uart_is_transmitting`=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for `uart_is_transmitting`=0, then go to IDLE.
- Selection in IDLE when unlocked: round-robin over `req_valid`. The search starts at (`rr_ptr`+1) mod NREQ; `rr_ptr` is the last granted index.
- Selection in IDLE when locked: only `lock_id` is eligible. Other requesters stall even if they are valid.
- `req_ready[i]` is combinational: high only in IDLE, for the selected i, and only when `req_valid[i]`=1.
- On acceptance:
  - latch the byte into `uart_tx_byte`;
  - `grant_id` = i and `rr_ptr` = i;
  - if `req_last[i]`=0, set `locked` and `lock_id` = i;
  - if `req_last[i]`=1, clear `locked`.
- `uart_tx_byte` holds its value from acceptance until the next acceptance.
- Exactly one `uart_transmit` pulse per accepted byte. `uart_transmit` is never asserted outside ISSUE.
- A locked requester that drops `req_valid` stalls the arbiter in IDLE with the lock held. The timeout feature below changes this.
- No byte is dropped or duplicated. At most one byte is in flight.

## Timing
- Reset values:
  - `req_ready`=0, `uart_transmit`=0, `uart_tx_byte`=0;
  - `grant_id`=0, `locked`=0, `busy`=0;
  - `rr_ptr`=NREQ-1, so requester 0 wins the first tie;
  - state=IDLE.
- Cycle sequence, with `uart` idle:
  - cycle 0: acceptance in IDLE;
  - cycle 1: ISSUE with `uart_transmit`=1;
  - cycle 2: WAIT_START, and `uart_is_transmitting` rises.
- Back-to-back throughput: the next acceptance happens in the first IDLE cycle after `uart_is_transmitting` falls.
- ISSUE while `uart_is_transmitting`=1: hold in ISSUE with `uart_transmit`=0 until it falls.
- All requesters valid simultaneously: grant order is 0, 1, …, NREQ-1, 0, … for single-byte frames.
- `rst` asserted in any state, including mid-frame: everything returns to reset values on the next edge and the lock is discarded. The `uart` instance shares `rst`.

## Configuration
- `UART_ARB_LOCK_TIMEOUT_EN` defined: a 16-bit counter counts consecutive IDLE cycles with `locked`=1 and `req_valid[lock_id]`=0.
  - When the count reaches `LOCK_TIMEOUT`, clear `locked` at the next edge. Normal round-robin resumes from `rr_ptr`.
  - The counter resets on any acceptance and on `rst`.
- `UART_ARB_LOCK_TIMEOUT_EN` undefined: there is no counter and the lock is held indefinitely.

## Structure
- Package `uart_arb_pkg`:
  - state enum (IDLE, ISSUE, WAIT_START, WAIT_DONE);
  - `ARB_MAX_REQ`=4;
  - index width function.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: request vector, `rr_ptr`.
  - Outputs: one-hot grant, index, any.
  - Instantiated once. Masking to `lock_id` happens outside it.

## Test plan
- Single byte: requester 0 sends 0x55 with last=1.
  - Required: `req_ready[0]` pulses once and `uart_transmit` pulses 1 cycle later with `uart_tx_byte`=0x55.
  - Required: `busy` falls after the `uart` `is_transmitting` falls.
- Fairness, NREQ=2: both requesters continuously send single-byte frames, 0xA0+n and 0xB0+n.
  - Required: the serial stream alternates A0, B0, A1, B1, ….
- Frame lock: requester 1 sends 0x10, 0x11, 0x12 (last on 0x12) while requester 0 is valid throughout.
  - Required: 10 11 12 go out contiguously, then requester 0's byte, and `locked` falls after 0x12 is accepted.
- Stall and timeout: lock on requester 0, then drop its valid for 2000 cycles while requester 1 is valid.
  - With `UART_ARB_LOCK_TIMEOUT_EN` and `LOCK_TIMEOUT`=1024: requester 1 is granted after 1024 idle cycles.
  - Without the macro: nothing is sent.
- Reset mid-frame: assert `rst` in WAIT_DONE while locked.
  - Required: all outputs return to reset values and the next grant goes to requester 0.
- Busy `uart`: hold `uart_is_transmitting`=1 externally during ISSUE for 50 cycles.
  - Required: `uart_transmit` stays low, then pulses exactly once after the release.
